// File: rtl/i2c_arb_pkg.sv
// Package for the I2C request arbiter.
// Holds the arbiter FSM state encoding and the default address/data widths
// shared by i2c_req_arbiter and its round-robin picker.
package i2c_arb_pkg;

  localparam int unsigned ARB_ADDR_W = 7;
  localparam int unsigned ARB_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req      in   N      request vector
//   last     in   IW     index granted most recently (search starts after it)
//   gnt      out  N      one-hot winner (all zero when no request)
//   gnt_idx  out  IW     winner index
//   any      out  1      at least one request present
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  int unsigned k;
  logic [IW-1:0] ki;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    k       = 0;
    ki      = '0;
    // Walk the ring starting just after last; the first hit wins, and the
    // last requester itself is checked only after every other one.
    for (int unsigned i = 1; i <= N; i++) begin
      k = int'(last) + i;
      if (k >= N) k = k - N;
      ki = IW'(k);
      if (!any && req[ki]) begin
        any     = 1'b1;
        gnt[ki] = 1'b1;
        gnt_idx = ki;
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one I2C master engine among NUM_REQ requesters with round-robin
// arbitration: accept one command, issue it, wait for completion, return the
// read byte and NACK status to the winner.
// Optional macro I2C_ARB_TIMEOUT_EN adds a WAIT-state watchdog that aborts the
// master after TIMEOUT_CYC cycles and reports an error.
// Ports:
//   clk_in, reset_in (async, active-low)
//   req_valid/req_ready/req_write/req_addr/req_data : requester command side
//   rsp_valid/rsp_data/rsp_err                       : one-cycle response
//   grant_id                                         : current owner index
//   mst_start/mst_write/mst_addr/mst_wdata/mst_abort : to the I2C master
//   mst_busy/mst_done/mst_rdata/mst_nack             : from the I2C master
module i2c_req_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ADDR_W      = ARB_ADDR_W,
  parameter int unsigned DATA_W      = ARB_DATA_W,
  parameter int unsigned TIMEOUT_CYC = 4096,
  localparam int unsigned IW         = $clog2(NUM_REQ)
) (
  input  logic                      clk_in,
  input  logic                      reset_in,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic [IW-1:0]             grant_id,
  output logic                      mst_start,
  output logic                      mst_write,
  output logic [ADDR_W-1:0]         mst_addr,
  output logic [DATA_W-1:0]         mst_wdata,
  output logic                      mst_abort,
  input  logic                      mst_busy,
  input  logic                      mst_done,
  input  logic [DATA_W-1:0]         mst_rdata,
  input  logic                      mst_nack
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("i2c_req_arbiter: NUM_REQ or TIMEOUT_CYC out of range");
  end

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     last_grant_q, last_grant_d;
  logic [IW-1:0]     grant_id_q, grant_id_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0] timer_q, timer_d;
`endif

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req     (req_valid),
    .last    (last_grant_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    req_ready    = '0;
    rsp_valid    = '0;
    rsp_data     = '0;
    rsp_err      = 1'b0;
    mst_start    = 1'b0;
    mst_abort    = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
    timer_d      = '0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        // Ready is masked while reset is held so every output reads zero.
        if (reset_in) req_ready = pick_gnt;
        if (pick_any) begin
          grant_id_d = pick_idx;
          write_d    = req_write[pick_idx];
          addr_d     = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          wdata_d    = req_data[int'(pick_idx)*DATA_W +: DATA_W];
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!mst_busy) begin
          mst_start = 1'b1;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mst_done) begin
          rdata_d = write_q ? '0 : mst_rdata;
          err_d   = mst_nack;
          state_d = ST_RESP;
        end
`ifdef I2C_ARB_TIMEOUT_EN
        else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          mst_abort = 1'b1;
          rdata_d   = '0;
          err_d     = 1'b1;
          state_d   = ST_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
`endif
      end
      ST_RESP: begin
        rsp_valid[grant_id_q] = 1'b1;
        rsp_data              = rdata_q;
        rsp_err               = err_q;
        last_grant_d          = grant_id_q;
        state_d               = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IW'(NUM_REQ - 1);
      grant_id_q   <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      timer_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
`ifdef I2C_ARB_TIMEOUT_EN
      timer_q      <= timer_d;
`endif
    end
  end

  assign grant_id  = grant_id_q;
  assign mst_write = write_q;
  assign mst_addr  = addr_q;
  assign mst_wdata = wdata_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
module tb_i2c_req_arbiter;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic [3:0]  req_valid, req_ready, req_write, rsp_valid;
  logic [27:0] req_addr;
  logic [31:0] req_data;
  logic [7:0]  rsp_data, mst_wdata, mst_rdata;
  logic        rsp_err, mst_start, mst_write, mst_abort;
  logic        mst_busy, mst_done, mst_nack;
  logic [1:0]  grant_id;
  logic [6:0]  mst_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk_in = ~clk_in;

  i2c_req_arbiter #(
    .NUM_REQ     (4),
    .ADDR_W      (7),
    .DATA_W      (8),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .grant_id  (grant_id),
    .mst_start (mst_start),
    .mst_write (mst_write),
    .mst_addr  (mst_addr),
    .mst_wdata (mst_wdata),
    .mst_abort (mst_abort),
    .mst_busy  (mst_busy),
    .mst_done  (mst_done),
    .mst_rdata (mst_rdata),
    .mst_nack  (mst_nack)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_req(input int i, input logic w, input logic [6:0] a, input logic [7:0] d);
    req_write[i]      = w;
    req_addr[i*7 +: 7] = a;
    req_data[i*8 +: 8] = d;
  endtask

  task automatic do_reset();
    reset_in  = 1'b0;
    req_valid = '0;
    mst_busy  = 1'b0;
    mst_done  = 1'b0;
    mst_nack  = 1'b0;
    mst_rdata = '0;
    tick();
    tick();
    reset_in = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_in  = 1'b0;
    req_valid = 4'b1111;
    mst_busy  = 1'b0;
    mst_done  = 1'b0;
    mst_nack  = 1'b0;
    mst_rdata = '0;
    req_write = '0;
    req_addr  = '0;
    req_data  = '0;
    tick();
    tick();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    checks++; if ({rsp_valid, rsp_data, rsp_err} !== 13'h0) begin errors++; $display("FAIL reset_rsp got %h want 0", {rsp_valid, rsp_data, rsp_err}); end
    checks++; if ({grant_id, mst_start, mst_write, mst_addr, mst_wdata, mst_abort} !== 21'h0) begin errors++;
      $display("FAIL reset_mst got %h want 0", {grant_id, mst_start, mst_write, mst_addr, mst_wdata, mst_abort}); end
    req_valid = '0;
    reset_in  = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    set_req(0, 1'b1, 7'h50, 8'hA5);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wr_ready got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (mst_start !== 1'b1) begin errors++; $display("FAIL wr_start got %b want 1", mst_start); end
    checks++; if ({mst_write, mst_addr, mst_wdata} !== {1'b1, 7'h50, 8'hA5}) begin errors++;
      $display("FAIL wr_cmd got %h want %h", {mst_write, mst_addr, mst_wdata}, {1'b1, 7'h50, 8'hA5}); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL wr_ready_busy got %b want 0000", req_ready); end
    tick();
    checks++; if (mst_start !== 1'b0) begin errors++; $display("FAIL wr_start_once got %b want 0", mst_start); end
    tick();
    mst_done  = 1'b1;
    mst_rdata = 8'h77;
    tick();
    mst_done = 1'b0;
    checks++; if ({rsp_valid, rsp_data, rsp_err} !== {4'b0001, 8'h00, 1'b0}) begin errors++;
      $display("FAIL wr_rsp got %b/%h/%b want 0001/00/0", rsp_valid, rsp_data, rsp_err); end
    tick();
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL wr_rsp_pulse got %b want 0000", rsp_valid); end
    checks++; if (mst_addr !== 7'h50) begin errors++; $display("FAIL wr_cmd_stable got %h want 50", mst_addr); end
  endtask

  task automatic test_round_robin();
    logic [1:0] ei;
    logic [3:0] eo;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 7'(7'h10 + i), 8'h00);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      ei = 2'(k % 4);
      eo = 4'b0001 << ei;
      #1;
      checks++; if (req_ready !== eo) begin errors++; $display("FAIL rr_ready[%0d] got %b want %b", k, req_ready, eo); end
      tick();
      checks++; if ({grant_id, mst_addr} !== {ei, 7'(7'h10 + ei)}) begin errors++;
        $display("FAIL rr_grant[%0d] got %0d/%h want %0d/%h", k, grant_id, mst_addr, ei, 7'(7'h10 + ei)); end
      tick();
      mst_done  = 1'b1;
      mst_rdata = 8'(8'h40 + k);
      tick();
      mst_done = 1'b0;
      checks++; if ({rsp_valid, rsp_data} !== {eo, 8'(8'h40 + k)}) begin errors++;
        $display("FAIL rr_rsp[%0d] got %b/%h want %b/%h", k, rsp_valid, rsp_data, eo, 8'(8'h40 + k)); end
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_read_nack();
    logic [7:0] rd [2];
    logic       nk [2];
    rd[0] = 8'h3C; nk[0] = 1'b0;
    rd[1] = 8'h99; nk[1] = 1'b1;
    set_req(2, 1'b0, 7'h2A, 8'hFF);
    for (int r = 0; r < 2; r++) begin
      req_valid = 4'b0100;
      tick();
      req_valid = '0;
      checks++; if ({grant_id, mst_write, mst_start} !== {2'd2, 1'b0, 1'b1}) begin errors++;
        $display("FAIL rd_issue[%0d] got %0d/%b/%b want 2/0/1", r, grant_id, mst_write, mst_start); end
      tick();
      mst_done  = 1'b1;
      mst_rdata = rd[r];
      mst_nack  = nk[r];
      tick();
      mst_done = 1'b0;
      mst_nack = 1'b0;
      checks++; if ({rsp_valid, rsp_data, rsp_err} !== {4'b0100, rd[r], nk[r]}) begin errors++;
        $display("FAIL rd_rsp[%0d] got %b/%h/%b want 0100/%h/%b", r, rsp_valid, rsp_data, rsp_err, rd[r], nk[r]); end
      tick();
    end
  endtask

  task automatic test_busy_hold();
    int starts;
    set_req(1, 1'b1, 7'h11, 8'h5A);
    req_valid = 4'b0010;
    mst_busy  = 1'b1;
    tick();
    req_valid = '0;
    starts = 0;
    for (int c = 0; c < 5; c++) begin
      if (mst_start !== 1'b0) starts++;
      if (c < 4) tick();
    end
    checks++; if (starts !== 0) begin errors++; $display("FAIL busy_nostart got %0d starts want 0", starts); end
    tick();
    mst_busy = 1'b0;
    #1;
    checks++; if ({mst_start, grant_id} !== {1'b1, 2'd1}) begin errors++;
      $display("FAIL busy_start got %b/%0d want 1/1", mst_start, grant_id); end
    tick();
    mst_done = 1'b1;
    tick();
    mst_done = 1'b0;
    checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL busy_rsp got %b want 0010", rsp_valid); end
    tick();
  endtask

  task automatic test_done_outside_wait();
    mst_done = 1'b1;
    tick();
    mst_done = 1'b0;
    tick();
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL stray_done got %b want 0000", rsp_valid); end
  endtask

  task automatic test_timeout();
    int aborts;
    int pulses;
    set_req(0, 1'b0, 7'h33, 8'h00);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    aborts = 0;
    pulses = 0;
`ifdef I2C_ARB_TIMEOUT_EN
    for (int c = 0; c < 15; c++) begin
      if (mst_abort !== 1'b0) aborts++;
      tick();
    end
    checks++; if (aborts !== 0) begin errors++; $display("FAIL to_early_abort got %0d want 0", aborts); end
    checks++; if (mst_abort !== 1'b1) begin errors++; $display("FAIL to_abort got %b want 1", mst_abort); end
    tick();
    checks++; if ({rsp_valid, rsp_data, rsp_err} !== {4'b0001, 8'h00, 1'b1}) begin errors++;
      $display("FAIL to_rsp got %b/%h/%b want 0001/00/1", rsp_valid, rsp_data, rsp_err); end
    tick();
`else
    for (int c = 0; c < 40; c++) begin
      if (mst_abort !== 1'b0) aborts++;
      if (rsp_valid !== 4'b0000) pulses++;
      tick();
    end
    checks++; if ({aborts, pulses} !== {32'd0, 32'd0}) begin errors++;
      $display("FAIL no_timeout got aborts=%0d rsp=%0d want 0/0", aborts, pulses); end
    mst_done = 1'b1;
    tick();
    mst_done = 1'b0;
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL late_done_rsp got %b want 0001", rsp_valid); end
    tick();
`endif
  endtask

  task automatic test_reset_mid_wait();
    int pulses;
    set_req(3, 1'b1, 7'h7E, 8'hC3);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    tick();
    checks++; if ({grant_id, mst_addr} !== {2'd3, 7'h7E}) begin errors++;
      $display("FAIL mid_setup got %0d/%h want 3/7e", grant_id, mst_addr); end
    req_valid = 4'b1111;
    reset_in  = 1'b0;
    #1;
    checks++; if ({req_ready, grant_id, mst_write, mst_addr, mst_wdata} !== 23'h0) begin errors++;
      $display("FAIL mid_async got %h want 0", {req_ready, grant_id, mst_write, mst_addr, mst_wdata}); end
    tick();
    tick();
    reset_in = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_win got %b want 0001", req_ready); end
    req_valid = '0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (rsp_valid[3] !== 1'b0) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL mid_lost_rsp got %0d want 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_read_nack();
    test_busy_hold();
    test_done_outside_wait();
    test_timeout();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
